// File: rtl/spram_delay_scheduler_pkg.sv
// Shared definitions for the SPRAM delay-line scheduler: state encoding and region sizing.
// No logic, so no latency.
// No flow control.
package spram_delay_scheduler_pkg;

    localparam int LEGAL_BITSIZE = 16;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_WR    = 3'd2,
        ST_RD    = 3'd3,
        ST_CAP   = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

    // Each channel owns an equal power-of-two slice of the RAM.
    function automatic int reglen_of(input int addrlen, input int nch);
        return addrlen - $clog2(nch);
    endfunction

endpackage

// File: rtl/spram_delay_scheduler_lrclk_edge.sv
// Registers lrclk twice and emits a one-cycle pulse on its rising edge.
// Pulse is high in the first cycle the first flop shows lrclk high.
// No flow control.
module lrclk_edge (
    input  logic clk,
    input  logic reset,
    input  logic lrclk,
    output logic frame_edge
);

    logic lr_q1;
    logic lr_q2;

    always_ff @(posedge clk) begin
        if (reset) begin
            lr_q1 <= 1'b0;
            lr_q2 <= 1'b0;
        end else begin
            lr_q1 <= lrclk;
            lr_q2 <= lr_q1;
        end
    end

    assign frame_edge = lr_q1 & ~lr_q2;

endmodule

// File: rtl/spram_delay_scheduler.sv
// Shares one 16Kx16 SPRAM among NCH delay lines: per frame a write, read and capture slot per channel.
// First write one cycle after the frame edge; rd_data and done land 1+3*NCH cycles after the edge.
// Edges arriving while busy are dropped and flagged in sticky overrun; edges during the clear are ignored.
module spram_delay_scheduler
    import spram_delay_scheduler_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int ADDRLEN = 14,
    parameter int NCH     = 4,
    parameter int REGLEN  = reglen_of(ADDRLEN, NCH)
) (
    input  logic                     bclk,
    input  logic                     reset,
    input  logic                     lrclk,
    input  logic [NCH-1:0]           enable,
    input  logic [NCH*REGLEN-1:0]    offset,
    input  logic [NCH*BITSIZE-1:0]   wr_data,
    output logic [NCH*BITSIZE-1:0]   rd_data,
    output logic                     done,
    output logic                     busy,
    output logic                     cleaning,
    output logic                     overrun,
    output logic [ADDRLEN-1:0]       mem_addr,
    output logic [BITSIZE-1:0]       mem_din,
    output logic                     mem_wren,
    input  logic [BITSIZE-1:0]       mem_dout
);

    localparam int              CHW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CHW-1:0]  LAST_CH = CHW'(NCH - 1);

    if (BITSIZE != LEGAL_BITSIZE) begin : g_bad_bitsize
        $error("spram_delay_scheduler: BITSIZE must be 16");
    end
    if (NCH < 1 || NCH > 8 || (NCH & (NCH - 1)) != 0) begin : g_bad_nch
        $error("spram_delay_scheduler: NCH must be a power of 2 in 1..8");
    end
    if (REGLEN != reglen_of(ADDRLEN, NCH)) begin : g_bad_reglen
        $error("spram_delay_scheduler: REGLEN must equal ADDRLEN - log2(NCH)");
    end

    sched_state_t        state;
    logic [CHW-1:0]      ch;
    logic [REGLEN-1:0]   wr_ptr;
    logic [BITSIZE-1:0]  wr_buf [NCH];
    logic [BITSIZE-1:0]  rd_buf [NCH];
    logic                frame_edge;

    lrclk_edge u_lrclk_edge (
        .clk        (bclk),
        .reset      (reset),
        .lrclk      (lrclk),
        .frame_edge (frame_edge)
    );

    // Channel number in the top bits keeps every region isolated.
    function automatic logic [ADDRLEN-1:0] slot_addr(input logic [CHW-1:0] c, input logic [REGLEN-1:0] p);
        return (ADDRLEN'(c) << REGLEN) | ADDRLEN'(p);
    endfunction

    always_ff @(posedge bclk) begin
        if (!reset && state == ST_IDLE && frame_edge) begin
            for (int c = 0; c < NCH; c++) wr_buf[c] <= wr_data[c*BITSIZE +: BITSIZE];
        end
        if (!reset && state == ST_CAP) rd_buf[ch] <= mem_dout;
    end

    always_ff @(posedge bclk) begin
        if (reset) begin
            state    <= ST_CLEAR;
            ch       <= '0;
            wr_ptr   <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wren <= 1'b1;
            rd_data  <= '0;
            done     <= 1'b0;
            busy     <= 1'b1;
            cleaning <= 1'b1;
            overrun  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (frame_edge && (state inside {ST_WR, ST_RD, ST_CAP, ST_DONE})) overrun <= 1'b1;
            case (state)
                ST_CLEAR: begin
                    // mem_addr doubles as the sweep counter; mem_din stays 0 throughout.
                    if (mem_addr == '1) begin
                        state    <= ST_IDLE;
                        mem_wren <= 1'b0;
                        cleaning <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (frame_edge) begin
                        state    <= ST_WR;
                        ch       <= '0;
                        busy     <= 1'b1;
                        mem_wren <= 1'b1;
                        mem_addr <= slot_addr('0, wr_ptr);
                        mem_din  <= wr_data[BITSIZE-1:0];
                    end
                end
                ST_WR: begin
                    state    <= ST_RD;
                    mem_wren <= 1'b0;
                    mem_addr <= slot_addr(ch, wr_ptr + offset[ch*REGLEN +: REGLEN]);
                end
                ST_RD: begin
                    state <= ST_CAP;
                end
                ST_CAP: begin
                    if (ch == LAST_CH) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        // The last channel's capture is still on mem_dout this cycle.
                        for (int c = 0; c < NCH; c++) begin
                            rd_data[c*BITSIZE +: BITSIZE] <= enable[c] ? ((c == NCH - 1) ? mem_dout : rd_buf[c])
                                                                       : wr_buf[c];
                        end
                    end else begin
                        state    <= ST_WR;
                        ch       <= ch + 1'b1;
                        mem_wren <= 1'b1;
                        mem_addr <= slot_addr(ch + 1'b1, wr_ptr);
                        mem_din  <= wr_buf[ch + 1'b1];
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    wr_ptr <= wr_ptr + 1'b1;
                end
                default: begin
                    state <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spram_delay_scheduler.sv
// Directed bench for spram_delay_scheduler with a behavioural SPRAM on the memory port.
module tb_spram_delay_scheduler;

    logic         bclk = 1'b0;
    logic         reset = 1'b1;
    logic         lrclk = 1'b0;
    logic [3:0]   enable = 4'hF;
    logic [47:0]  offset = '0;
    logic [63:0]  wr_data = '0;
    logic [63:0]  rd_data;
    logic         done, busy, cleaning, overrun;
    logic [13:0]  mem_addr;
    logic [15:0]  mem_din;
    logic         mem_wren;
    logic [15:0]  mem_dout;

    logic [15:0]  spram [0:16383];

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0]  la  [32];
    logic         lw  [32];
    logic [15:0]  ld  [32];
    logic         ldn [32];
    logic         lo  [32];
    logic [63:0]  lrd [32];

    spram_delay_scheduler dut (
        .bclk     (bclk),
        .reset    (reset),
        .lrclk    (lrclk),
        .enable   (enable),
        .offset   (offset),
        .wr_data  (wr_data),
        .rd_data  (rd_data),
        .done     (done),
        .busy     (busy),
        .cleaning (cleaning),
        .overrun  (overrun),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wren (mem_wren),
        .mem_dout (mem_dout)
    );

    always #5 bclk = ~bclk;

    always @(posedge bclk) begin
        if (mem_wren) spram[mem_addr] <= mem_din;
        else          mem_dout <= spram[mem_addr];
    end

    // One frame edge, optional second edge at E+second_k; index k of the logs is cycle E+k.
    task automatic run_frame(input int second_k);
        @(negedge bclk);
        lrclk = 1'b1;
        for (int k = 0; k < 32; k++) begin
            @(negedge bclk);
            la[k] = mem_addr; lw[k] = mem_wren; ld[k] = mem_din;
            ldn[k] = done; lo[k] = overrun; lrd[k] = rd_data;
            if (k == 0) lrclk = 1'b0;
            if (second_k > 0 && k == second_k - 1) lrclk = 1'b1;
            if (second_k > 0 && k == second_k) lrclk = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge bclk);
        n_cmp++; if (mem_addr !== 14'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        n_cmp++; if (mem_din !== 16'h0) begin n_bad++; $display("FAIL reset_mem_din: got %h want 0000", mem_din); end
        n_cmp++; if (mem_wren !== 1'b1) begin n_bad++; $display("FAIL reset_mem_wren: got %b want 1", mem_wren); end
        n_cmp++; if (rd_data !== 64'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        n_cmp++; if ({done, busy, cleaning, overrun} !== 4'b0110) begin
            n_bad++; $display("FAIL reset_flags: got done/busy/cleaning/overrun=%b want 0110", {done, busy, cleaning, overrun});
        end
    endtask

    task automatic test_clear();
        int i = 0;
        int addr_err = 0;
        int flag_err = 0;
        reset = 1'b0;
        while (cleaning === 1'b1 && i < 20000) begin
            if (mem_addr !== i[13:0] || mem_wren !== 1'b1 || mem_din !== 16'h0) addr_err++;
            if (done !== 1'b0 || overrun !== 1'b0) flag_err++;
            lrclk = (i % 64) >= 32;
            i++;
            @(negedge bclk);
        end
        n_cmp++; if (i !== 16384) begin n_bad++; $display("FAIL clear_length: got %0d cycles want 16384", i); end
        n_cmp++; if (addr_err !== 0) begin n_bad++; $display("FAIL clear_sweep: got %0d bad cycles want 0", addr_err); end
        n_cmp++; if (flag_err !== 0) begin n_bad++; $display("FAIL clear_edges: got %0d done/overrun cycles want 0", flag_err); end
        n_cmp++; if ({busy, mem_wren} !== 2'b00) begin n_bad++; $display("FAIL clear_exit: got busy/wren=%b want 00", {busy, mem_wren}); end
        lrclk = 1'b0;
        repeat (4) @(negedge bclk);
        n_cmp++; if ({done, busy, overrun} !== 3'b000) begin n_bad++; $display("FAIL clear_idle: got %b want 000", {done, busy, overrun}); end
    endtask

    task automatic test_same_frame();
        int n = 0;
        wr_data = 64'h4444_3333_2222_1234;
        offset = '0;
        enable = 4'hF;
        run_frame(0);
        for (int k = 0; k < 32; k++) n += int'(ldn[k]);
        n_cmp++; if (lw[0] !== 1'b0) begin n_bad++; $display("FAIL f0_idle_wren: got %b want 0", lw[0]); end
        n_cmp++; if ({la[1], lw[1], ld[1]} !== {14'h0000, 1'b1, 16'h1234}) begin
            n_bad++; $display("FAIL f0_wr_slot: got addr %h wren %b din %h want 0000 1 1234", la[1], lw[1], ld[1]);
        end
        n_cmp++; if ({la[2], lw[2]} !== {14'h0000, 1'b0}) begin n_bad++; $display("FAIL f0_rd_slot: got %h %b want 0000 0", la[2], lw[2]); end
        n_cmp++; if ({ldn[12], ldn[13], ldn[14]} !== 3'b010) begin
            n_bad++; $display("FAIL f0_done_timing: got E+12..14=%b want 010", {ldn[12], ldn[13], ldn[14]});
        end
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL f0_done_count: got %0d want 1", n); end
        n_cmp++; if (lrd[13] !== 64'h4444_3333_2222_1234) begin n_bad++; $display("FAIL f0_rd_data: got %h want 4444333322221234", lrd[13]); end
    endtask

    task automatic test_offset_wrap();
        wr_data[31:16] = 16'h0100;
        offset[23:12] = 12'hFFF;
        run_frame(0);
        n_cmp++; if ({la[5], lw[5]} !== {14'h1000, 1'b0}) begin n_bad++; $display("FAIL f1_rd_addr: got %h %b want 1000 0", la[5], lw[5]); end
        n_cmp++; if (lrd[13][31:16] !== 16'h2222) begin n_bad++; $display("FAIL f1_rd_data1: got %h want 2222", lrd[13][31:16]); end
        wr_data[31:16] = 16'h0555;
        run_frame(0);
        n_cmp++; if (lrd[12] !== 64'h4444_3333_2222_1234) begin n_bad++; $display("FAIL f2_rd_hold: got %h want 4444333322221234", lrd[12]); end
        n_cmp++; if ({la[4], lw[4], ld[4]} !== {14'h1002, 1'b1, 16'h0555}) begin
            n_bad++; $display("FAIL f2_wr_slot1: got %h %b %h want 1002 1 0555", la[4], lw[4], ld[4]);
        end
        n_cmp++; if (la[5] !== 14'h1001) begin n_bad++; $display("FAIL f2_rd_addr: got %h want 1001", la[5]); end
        n_cmp++; if (lrd[13][31:16] !== 16'h0100) begin n_bad++; $display("FAIL f2_rd_data1: got %h want 0100", lrd[13][31:16]); end
    endtask

    // Frames every 14 cycles: the next edge lands on the first IDLE cycle after DONE.
    task automatic test_back_to_back();
        int n = 0;
        int ov = 0;
        wr_data = 64'h0ABC_1111_0BBB_0AAA;
        for (int f = 0; f < 4092; f++) begin
            for (int k = 0; k < 14; k++) begin
                @(negedge bclk);
                n += int'(done);
                if (overrun !== 1'b0) ov++;
                lrclk = (k == 0);
            end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge bclk);
            n += int'(done);
            if (overrun !== 1'b0) ov++;
        end
        n_cmp++; if (n !== 4092) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 4092", n); end
        n_cmp++; if (ov !== 0) begin n_bad++; $display("FAIL b2b_overrun: got %0d cycles want 0", ov); end
    endtask

    task automatic test_region_wrap();
        wr_data = 64'h5A5A_1111_0BBB_0AAA;
        offset[47:36] = 12'd10;
        run_frame(0);
        n_cmp++; if ({la[10], lw[10], ld[10]} !== {14'h3FFF, 1'b1, 16'h5A5A}) begin
            n_bad++; $display("FAIL wrap_wr_slot3: got %h %b %h want 3FFF 1 5A5A", la[10], lw[10], ld[10]);
        end
        n_cmp++; if ({la[11], lw[11]} !== {14'h3009, 1'b0}) begin n_bad++; $display("FAIL wrap_rd_addr3: got %h %b want 3009 0", la[11], lw[11]); end
        n_cmp++; if (lrd[13][63:48] !== 16'h0ABC) begin n_bad++; $display("FAIL wrap_rd_data3: got %h want 0ABC", lrd[13][63:48]); end
    endtask

    task automatic test_disabled();
        enable = 4'b1011;
        wr_data[47:32] = 16'h7FFF;
        offset[35:24] = 12'hFFF;
        run_frame(0);
        n_cmp++; if ({la[1], lw[1]} !== {14'h0000, 1'b1}) begin n_bad++; $display("FAIL dis_ptr_wrapped: got %h %b want 0000 1", la[1], lw[1]); end
        n_cmp++; if ({la[7], lw[7], ld[7]} !== {14'h2000, 1'b1, 16'h7FFF}) begin
            n_bad++; $display("FAIL dis_wr_slot2: got %h %b %h want 2000 1 7FFF", la[7], lw[7], ld[7]);
        end
        n_cmp++; if (la[8] !== 14'h2FFF) begin n_bad++; $display("FAIL dis_rd_addr2: got %h want 2FFF", la[8]); end
        n_cmp++; if (lrd[13][47:32] !== 16'h7FFF) begin n_bad++; $display("FAIL dis_rd_data2: got %h want 7FFF", lrd[13][47:32]); end
        n_cmp++; if (lrd[13][63:48] !== 16'h0ABC) begin n_bad++; $display("FAIL dis_rd_data3: got %h want 0ABC", lrd[13][63:48]); end
        enable = 4'hF;
    endtask

    task automatic test_overrun_reset();
        int n = 0;
        run_frame(5);
        for (int k = 0; k < 32; k++) n += int'(ldn[k]);
        n_cmp++; if ({lo[5], lo[6]} !== 2'b01) begin n_bad++; $display("FAIL ovr_set: got E+5/E+6=%b want 01", {lo[5], lo[6]}); end
        n_cmp++; if (n !== 1) begin n_bad++; $display("FAIL ovr_done_count: got %0d want 1", n); end
        @(negedge bclk);
        lrclk = 1'b1;
        for (int k = 0; k < 11; k++) begin
            @(negedge bclk);
            if (k == 0) lrclk = 1'b0;
            if (k == 6) begin
                n_cmp++; if ({overrun, busy} !== 2'b11) begin n_bad++; $display("FAIL ovr_sticky: got ovr/busy=%b want 11", {overrun, busy}); end
                reset = 1'b1;
            end
            if (k == 7) begin
                n_cmp++; if ({rd_data, mem_addr} !== {64'h0, 14'h0}) begin
                    n_bad++; $display("FAIL rst_mid_data: got rd %h addr %h want 0 0000", rd_data, mem_addr);
                end
                n_cmp++; if ({done, busy, cleaning, overrun, mem_wren} !== 5'b01101) begin
                    n_bad++; $display("FAIL rst_mid_flags: got %b want 01101", {done, busy, cleaning, overrun, mem_wren});
                end
                reset = 1'b0;
            end
            if (k == 10) begin
                n_cmp++; if ({mem_addr, cleaning} !== {14'h0003, 1'b1}) begin
                    n_bad++; $display("FAIL rst_clear_restart: got addr %h cleaning %b want 0003 1", mem_addr, cleaning);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_same_frame();
        test_offset_wrap();
        test_back_to_back();
        test_region_wrap();
        test_disabled();
        test_overrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spram_delay_scheduler.md
# spram_delay_scheduler

Time-multiplexes one 16K×16 SB_SPRAM256KA among NCH independent delay lines (echo/delay effects), so one single-port RAM serves every channel of the audio path. Once per lrclk frame it sequences a write slot, a delayed-read slot and a capture slot per channel. After reset it sweeps the whole RAM to zero before serving frames. It sits between the per-channel effect datapaths, which compute feedback and mixing, and the SPRAM primitive, which is instantiated by the parent.

## Interface
- BITSIZE, 16: sample width. Only 16 is legal; any other value raises an elaboration error.
- ADDRLEN, 14: SPRAM address width.
- NCH, 4: number of delay lines. Must be a power of 2, 1..8.
- REGLEN, ADDRLEN − log2(NCH): derived address width of each channel region (12 by default).

Ports:
- bclk  in  1  clock (64×lrclk).
- reset  in  1  synchronous, active-high.
- lrclk  in  1  frame clock, generated in the bclk domain.
- enable  in  NCH  per-channel delay enable.
- offset  in  NCH*REGLEN  per-channel read offset, channel c at [c*REGLEN +: REGLEN].
- wr_data  in  NCH*BITSIZE  signed samples to store, packed the same way.
- rd_data  out  NCH*BITSIZE  signed delayed samples, registered.
- done  out  1  one-cycle pulse when rd_data updates.
- busy  out  1  clearing or sequencing.
- cleaning  out  1  clear sweep in progress.
- overrun  out  1  sticky; a frame edge arrived while sequencing.
- mem_addr  out  ADDRLEN  SPRAM ADDRESS.
- mem_din  out  BITSIZE  SPRAM DATAIN.
- mem_wren  out  1  SPRAM WREN.
- mem_dout  in  BITSIZE  SPRAM DATAOUT.

## Operation
- States: CLEAR, IDLE, WR, RD, CAP, DONE.
- Reset values: mem_addr=0, mem_din=0, mem_wren=1, rd_data=0, done=0, busy=1, cleaning=1, overrun=0, wr_ptr=0, state=CLEAR.
- CLEAR:
  - Each cycle, write 0 to address clr_addr; clr_addr runs 0..2^ADDRLEN−1.
  - After the write to the last address, go to IDLE, with cleaning=0 and busy=0.
  - Frame edges during CLEAR are ignored and do not set overrun.
- Frame edge:
  - lrclk is registered twice; edge = lr_q1 & ~lr_q2.
  - In IDLE, an edge latches all of wr_data into wr_buf, sets ch=0 and moves to WR.
- Per channel c:
  - WR: mem_wren=1, mem_addr={c, wr_ptr}, mem_din=wr_buf[c].
  - RD: mem_wren=0, mem_addr={c, (wr_ptr+offset[c]) mod 2^REGLEN}.
  - CAP: rd_buf[c]=mem_dout.
  - After CAP, go to WR of c+1; after the last channel, go to DONE.
- DONE:
  - For each channel, rd_data[c] = enable[c] ? rd_buf[c] : wr_buf[c].
  - done=1 for this cycle, wr_ptr increments (wraps at 2^REGLEN), then IDLE.
- Disabled channels are still written, so their history is valid when re-enabled.
- Delay in frames = (2^REGLEN − offset) mod 2^REGLEN. offset=0 returns the sample written in the same frame.
- Regions are isolated: address bits [ADDRLEN−1:REGLEN] always equal c.
- An edge in WR/RD/CAP/DONE sets overrun. The edge is dropped and the current sequence completes normally.
- mem_wren=0 in IDLE, RD, CAP and DONE.
- reset asserted mid-frame or mid-clear aborts the operation and restores all reset values. The full clear restarts.

## Timing
- Edge seen at bclk cycle E (lr_q1 first high) → WR of ch0 at E+1.
- Each channel takes 3 cycles; DONE falls at E+1+3*NCH (E+13 for NCH=4). This is well inside 64 bclk.
- SPRAM read latency is 1 cycle: address in RD, data sampled in CAP.
- wr_data is sampled only at the edge cycle; it may change afterwards.
- rd_data is stable from DONE until the next DONE.
- Clear duration: 2^ADDRLEN cycles (16384) after reset deasserts.

## Structure
- Shared include delay_sched_defs.vh holds:
  - state encoding localparams (ST_CLEAR…ST_DONE);
  - REGLEN derivation;
  - the BITSIZE legality check.
- One sub-module: lrclk_edge (two-flop register plus rising-edge pulse), reused by other frame-synchronous blocks.
- The SPRAM instance stays in the parent.

## Test plan
1. Release reset → cleaning=1 for exactly 16384 cycles, mem_wren=1, mem_din=0, addresses 0..16383 in order. lrclk edges in this window give no done and overrun=0.
2. NCH=4, offset[0]=0, wr_data[0]=0x1234, edge → done 13 cycles after E, rd_data[0]=0x1234.
3. offset[1]=4095 → the frame k write of 0x0100 appears in rd_data[1] at frame k+1; read address = 0x1000 | (wr_ptr−1).
4. wr_ptr=4095, offset[3]=10 → RD address 0x3009, write address 0x3FFF; wr_ptr becomes 0 after DONE.
5. enable[2]=0, wr_data[2]=0x7FFF → rd_data[2]=0x7FFF, and the WR slot still writes 0x7FFF at {2, wr_ptr}.
6. Second edge 5 cycles after the first → overrun=1, exactly one done pulse. Reset at E+6 → next cycle state=CLEAR, rd_data=0, mem_addr=0, overrun=0.
